ahb_fifo_sync_core: RTL
=======================

# ahb_fifo_sync_core

Single-clock FIFO storage core consumed by the AHB FIFO slave interface when both ports sit on AHB (synchronous mode). Accepts the slave's `wen`/`ren`/`wdata`/`fifo_clr` and threshold registers; returns `rdata`, occupancy counts and the six status flags behind the slave's status and interrupt registers. Standard-read or first-word-fall-through (FWFT) read behaviour is selected at compile time.

## Interface
- `DATA_WIDTH`, 32: word width.
- `ADDR_WIDTH`, 9: RAM address width. Capacity `CAP = 2^ADDR_WIDTH - 1` words, so counts fit `ADDR_WIDTH` bits.

- `hclk`  in  1  clock.
- `hresetn`  in  1  reset: asynchronous, active-low.
- `fifo_clr`  in  1  synchronous clear, level-sensitive.
- `wen`  in  1  write strobe.
- `wdata`  in  DATA_WIDTH  write word.
- `ren`  in  1  read/pop strobe.
- `rdata`  out  DATA_WIDTH  read word.
- `prog_full_thresh`, `prog_full_assert`, `prog_full_negate`  in  ADDR_WIDTH each  programmable-full controls.
- `prog_empty_thresh`, `prog_empty_assert`, `prog_empty_negate`  in  ADDR_WIDTH each  programmable-empty controls.
- `wfull`, `rempty`, `almost_full`, `almost_empty`, `prog_full`, `prog_empty`  out  1 each  status flags.
- `wr_data_cnt`, `rd_data_cnt`  out  ADDR_WIDTH each  occupancy; equal in this core.

## Operation
- Reset values: `rdata` 0, both counts 0, `rempty` 1, `almost_empty` 1, `prog_empty` 1, `wfull` 0, `almost_full` 0, `prog_full` 0. Pointers are 0. RAM contents are not reset.
- Write accepted when `wen && !wfull`. Read accepted when `ren && !rempty`. Rejected strobes change nothing and raise no error.
- Simultaneous accepted read and write: both pointers advance and the count is unchanged.
- Full with `wen && ren`: only the read is performed.
- Empty with `wen && ren`: only the write is performed.
- Pointers are `ADDR_WIDTH` bits and wrap naturally from `2^ADDR_WIDTH - 1` to 0. Full/empty are derived from the count, not from pointer comparison.
- Flags are registered from the next-state count `n`:
  - `wfull` = (n == CAP); `rempty` = (n == 0).
  - `almost_full` = (n >= CAP-1); `almost_empty` = (n <= 1).
- `prog_full`:
  - If `prog_full_assert` and `prog_full_negate` are both nonzero (hysteresis mode): set when n >= assert, clear when n < negate, otherwise hold.
  - Else: `prog_full` = (n >= `prog_full_thresh`).
- `prog_empty`:
  - Hysteresis mode: set when n <= assert, clear when n > negate, otherwise hold.
  - Else: `prog_empty` = (n <= `prog_empty_thresh`).
- Threshold inputs are sampled every cycle. A change takes effect on the next edge.
- `fifo_clr` overrides `wen`/`ren` in the same cycle. It forces pointers, counts, flags and `rdata` to their reset values on the next edge and holds them there while asserted.

## Timing
- Standard mode: `rdata` is the RAM word registered on the edge that accepts `ren`. It is valid the cycle after the read strobe and held until the next accepted read. This matches the AHB data phase following the address phase.
- Write to `rempty` falling: 1 cycle (the edge that accepts the write).
- Count and flags update on the same edge as the accepted access.
- `hresetn` asserted mid-transfer clears state asynchronously. The first access is accepted on the first edge after deassertion.

## Configuration
- `AHB_FIFO_FWFT_EN` defined: FWFT read.
  - A 1-word output register prefetches the head of the FIFO.
  - `rdata` shows the head word while `rempty` = 0. `ren` pops it, and the next word appears on the same edge if the RAM holds one.
  - Count and flags include the output-register word.
  - Write into an empty FIFO to `rempty` falling: 2 cycles.
- Not defined: standard read as described under Timing. No prefetch logic is synthesised.

## Structure
- Shared package/header `ahb_fifo_pkg`:
  - Status-vector bit positions {prog_empty, prog_full, almost_empty, almost_full, rempty, wfull} = bits 5..0, shared with the AHB slave register map.
  - `CAP` computation and flag reset constants.
- Sub-module `ahb_fifo_dpram`: simple dual-port RAM, one write port and one registered read port, 2^ADDR_WIDTH × DATA_WIDTH.
- Pointers, count, flag logic and the FWFT stage live in the core.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 → counts 3, `rempty` 0, `almost_empty` 0. Three reads return 0x11, 0x22, 0x33 in order, one cycle after each `ren`.
- ADDR_WIDTH=4: write 15 words → `wfull` 1, `almost_full` set at count 14. A 16th write is ignored. Read all 15 words across the pointer wrap; order is preserved.
- Count 5, `wen` and `ren` together for 10 cycles → count stays 5 and data order is intact. At empty, `wen && ren` → count 1 and `rdata` unchanged.
- Hysteresis mode, `prog_full_assert`=10, `prog_full_negate`=6: `prog_full` rises on write 10, stays high down to count 6, and falls when count reaches 5.
- Count 7 with `fifo_clr` pulsed together with `wen` → next cycle counts 0, `rempty` 1, `rdata` 0, and the write is discarded.
- `AHB_FIFO_FWFT_EN` build: a write of 0xA5 to an empty FIFO → `rdata`=0xA5 and `rempty`=0 two cycles later, with no `ren` issued.

Source files
------------

// File: rtl/ahb_fifo_pkg.sv
// Shared constants for the AHB FIFO: status-vector bit map, capacity helper and flag reset values.
package ahb_fifo_pkg;

  localparam int unsigned STAT_WFULL        = 0;
  localparam int unsigned STAT_REMPTY       = 1;
  localparam int unsigned STAT_ALMOST_FULL  = 2;
  localparam int unsigned STAT_ALMOST_EMPTY = 3;
  localparam int unsigned STAT_PROG_FULL    = 4;
  localparam int unsigned STAT_PROG_EMPTY   = 5;
  localparam int unsigned STAT_W            = 6;

  // Field order matches the bit positions above (prog_empty is bit 5).
  typedef struct packed {
    logic prog_empty;
    logic prog_full;
    logic almost_empty;
    logic almost_full;
    logic rempty;
    logic wfull;
  } fifo_stat_t;

  localparam fifo_stat_t STAT_RST = '{
    prog_empty:   1'b1,
    prog_full:    1'b0,
    almost_empty: 1'b1,
    almost_full:  1'b0,
    rempty:       1'b1,
    wfull:        1'b0
  };

  // One slot is sacrificed so the count always fits in aw bits.
  function automatic int unsigned fifo_cap(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

endpackage

// File: rtl/ahb_fifo_dpram.sv
// Simple dual-port RAM: one write port, one registered read port with reset/clear of the read register.
module ahb_fifo_dpram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic                  rclr,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge hclk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register doubles as the visible rdata, so it follows reset and clear.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)  rdata <= '0;
    else if (rclr) rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_fifo_sync_core.sv
// Single-clock FIFO core behind the AHB FIFO slave: pointers, occupancy, status flags.
// Define AHB_FIFO_FWFT_EN for first-word-fall-through reads; default is standard registered read.
module ahb_fifo_sync_core
  import ahb_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  fifo_clr,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [ADDR_WIDTH-1:0] prog_full_thresh,
  input  logic [ADDR_WIDTH-1:0] prog_full_assert,
  input  logic [ADDR_WIDTH-1:0] prog_full_negate,
  input  logic [ADDR_WIDTH-1:0] prog_empty_thresh,
  input  logic [ADDR_WIDTH-1:0] prog_empty_assert,
  input  logic [ADDR_WIDTH-1:0] prog_empty_negate,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  prog_full,
  output logic                  prog_empty,
  output logic [ADDR_WIDTH-1:0] wr_data_cnt,
  output logic [ADDR_WIDTH-1:0] rd_data_cnt
);

  localparam logic [ADDR_WIDTH-1:0] CAP     = ADDR_WIDTH'(fifo_cap(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wptr_q, rptr_q, cnt_q, cnt_n;
  fifo_stat_t            stat_q, stat_n;
  logic [STAT_W-1:0]     stat_vec;
  logic                  wr_acc, rd_acc, ram_re, empty_n;

  // Clear wins over both strobes in the same cycle.
  assign wr_acc = wen & ~stat_q.wfull  & ~fifo_clr;
  assign rd_acc = ren & ~stat_q.rempty & ~fifo_clr;

  always_comb begin
    cnt_n = cnt_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_n = cnt_q + CNT_ONE;
      2'b01:   cnt_n = cnt_q - CNT_ONE;
      default: cnt_n = cnt_q;
    endcase
  end

`ifdef AHB_FIFO_FWFT_EN
  // RAM read register acts as the output stage; refill it whenever it is empty or being popped.
  logic [ADDR_WIDTH-1:0] ram_cnt_q;
  logic                  out_vld_q, out_vld_n, prefetch;

  assign prefetch  = (ram_cnt_q != '0) & (~out_vld_q | rd_acc) & ~fifo_clr;
  assign out_vld_n = prefetch | (out_vld_q & ~rd_acc);
  assign ram_re    = prefetch;
  assign empty_n   = ~out_vld_n;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ram_cnt_q <= '0;
      out_vld_q <= 1'b0;
    end else if (fifo_clr) begin
      ram_cnt_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      ram_cnt_q <= ram_cnt_q + ADDR_WIDTH'(wr_acc) - ADDR_WIDTH'(prefetch);
      out_vld_q <= out_vld_n;
    end
  end
`else
  assign ram_re  = rd_acc;
  assign empty_n = (cnt_n == '0);
`endif

  // Flags follow the next-state count; prog flags hold inside the hysteresis band.
  always_comb begin
    stat_n              = stat_q;
    stat_n.wfull        = (cnt_n == CAP);
    stat_n.rempty       = empty_n;
    stat_n.almost_full  = (cnt_n >= (CAP - CNT_ONE));
    stat_n.almost_empty = (cnt_n <= CNT_ONE);
    if ((prog_full_assert != '0) && (prog_full_negate != '0)) begin
      if (cnt_n >= prog_full_assert)     stat_n.prog_full = 1'b1;
      else if (cnt_n < prog_full_negate) stat_n.prog_full = 1'b0;
    end else begin
      stat_n.prog_full = (cnt_n >= prog_full_thresh);
    end
    if ((prog_empty_assert != '0) && (prog_empty_negate != '0)) begin
      if (cnt_n <= prog_empty_assert)      stat_n.prog_empty = 1'b1;
      else if (cnt_n > prog_empty_negate)  stat_n.prog_empty = 1'b0;
    end else begin
      stat_n.prog_empty = (cnt_n <= prog_empty_thresh);
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      stat_q <= STAT_RST;
    end else if (fifo_clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      stat_q <= STAT_RST;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + CNT_ONE;
      if (ram_re) rptr_q <= rptr_q + CNT_ONE;
      cnt_q  <= cnt_n;
      stat_q <= stat_n;
    end
  end

  ahb_fifo_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .hclk    (hclk),
    .hresetn (hresetn),
    .we      (wr_acc),
    .waddr   (wptr_q),
    .wdata   (wdata),
    .re      (ram_re),
    .rclr    (fifo_clr),
    .raddr   (rptr_q),
    .rdata   (rdata)
  );

  assign stat_vec     = stat_q;
  assign wfull        = stat_vec[STAT_WFULL];
  assign rempty       = stat_vec[STAT_REMPTY];
  assign almost_full  = stat_vec[STAT_ALMOST_FULL];
  assign almost_empty = stat_vec[STAT_ALMOST_EMPTY];
  assign prog_full    = stat_vec[STAT_PROG_FULL];
  assign prog_empty   = stat_vec[STAT_PROG_EMPTY];
  assign wr_data_cnt  = cnt_q;
  assign rd_data_cnt  = cnt_q;

endmodule
